// File: rtl/ps2_scancode_decoder_if.sv
// Key-event bus between the scan-code decoder and its CPU/IO-bus consumer.
// The decoder drives the head event; the consumer answers with ev_ready.
interface ps2_scancode_decoder_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic [7:0] ev_ascii;

  modport master (
    output ev_valid, ev_code, ev_ext, ev_break, ev_ascii,
    input  ev_ready
  );

  modport slave (
    input  ev_valid, ev_code, ev_ext, ev_break, ev_ascii,
    output ev_ready
  );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan-code decoder: strips E0/F0/E1 prefixes, tracks shift and caps lock,
// translates make codes to ASCII and queues key events in a small valid/ready FIFO.
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  ps2_scancode_decoder_if.master        ev,
  output logic                          shift_held,
  output logic                          caps_lock,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [7:0] ascii;
  } event_t;

  // ---------------------------------------------------------------------------
  // Translation helpers
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] letter_of(input logic [7:0] code);
    case (code)
      8'h1C: letter_of = "a";  8'h32: letter_of = "b";  8'h21: letter_of = "c";
      8'h23: letter_of = "d";  8'h24: letter_of = "e";  8'h2B: letter_of = "f";
      8'h34: letter_of = "g";  8'h33: letter_of = "h";  8'h43: letter_of = "i";
      8'h3B: letter_of = "j";  8'h42: letter_of = "k";  8'h4B: letter_of = "l";
      8'h3A: letter_of = "m";  8'h31: letter_of = "n";  8'h44: letter_of = "o";
      8'h4D: letter_of = "p";  8'h15: letter_of = "q";  8'h2D: letter_of = "r";
      8'h1B: letter_of = "s";  8'h2C: letter_of = "t";  8'h3C: letter_of = "u";
      8'h2A: letter_of = "v";  8'h1D: letter_of = "w";  8'h22: letter_of = "x";
      8'h35: letter_of = "y";  8'h1A: letter_of = "z";
      default: letter_of = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] digit_of(input logic [7:0] code, input logic shift);
    case (code)
      8'h16: digit_of = shift ? "!" : "1";
      8'h1E: digit_of = shift ? "@" : "2";
      8'h26: digit_of = shift ? "#" : "3";
      8'h25: digit_of = shift ? "$" : "4";
      8'h2E: digit_of = shift ? "%" : "5";
      8'h36: digit_of = shift ? "^" : "6";
      8'h3D: digit_of = shift ? "&" : "7";
      8'h3E: digit_of = shift ? "*" : "8";
      8'h46: digit_of = shift ? "(" : "9";
      8'h45: digit_of = shift ? ")" : "0";
      default: digit_of = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] translate(input logic [7:0] code, input logic shift,
                                           input logic caps);
    logic [7:0] letter;
    letter = letter_of(code);
    if (letter != 8'h00)
      translate = (shift ^ caps) ? (letter - 8'h20) : letter;
    else begin
      case (code)
        8'h29:   translate = 8'h20;
        8'h5A:   translate = 8'h0D;
        8'h66:   translate = 8'h08;
        8'h76:   translate = 8'h1B;
        default: translate = digit_of(code, shift);
      endcase
    end
  endfunction

  function automatic logic is_shift(input logic [7:0] code);
    is_shift = (code == 8'h12) || (code == 8'h59);
  endfunction

  // ---------------------------------------------------------------------------
  // Prefix FSM
  // ---------------------------------------------------------------------------
  state_t     state, state_next;
  logic [2:0] skip_cnt, skip_next;
  logic       emit, emit_ext, emit_brk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      skip_cnt <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state    <= state_next;
      skip_cnt <= skip_next;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
    state_next = state;
    skip_next  = skip_cnt;
    if (rx_valid) begin
      case (state)
        IDLE: begin
          if (rx_data == 8'hE0)      state_next = EXT;
          else if (rx_data == 8'hF0) state_next = BRK;
          else if (rx_data == 8'hE1) begin
            state_next = SKIP;
            skip_next  = 3'd7;
          end
        end
        EXT:     state_next = (rx_data == 8'hF0) ? EXT_BRK : IDLE;
        BRK:     state_next = IDLE;
        EXT_BRK: state_next = IDLE;
        SKIP: begin
          skip_next = skip_cnt - 3'd1;
          if (skip_cnt == 3'd1) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    emit     = 1'b0;
    emit_ext = 1'b0;
    emit_brk = 1'b0;
    if (rx_valid) begin
      case (state)
        IDLE: begin
          case (rx_data)
            8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'h00, 8'hFF: emit = 1'b0;
            default: emit = 1'b1;
          endcase
        end
        EXT: begin
          emit     = (rx_data != 8'hF0) && !is_shift(rx_data);
          emit_ext = 1'b1;
        end
        BRK: begin
          emit     = 1'b1;
          emit_brk = 1'b1;
        end
        EXT_BRK: begin
          // E0-prefixed shift codes are the keyboard's fake shifts around nav keys.
          emit     = !is_shift(rx_data);
          emit_ext = 1'b1;
          emit_brk = 1'b1;
        end
        default: emit = 1'b0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Modifier tracking
  // ---------------------------------------------------------------------------
  logic lshift, rshift, caps_held;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      caps_held <= 1'b0;
      caps_lock <= 1'b0;
    end else if (emit && !emit_ext) begin
      case (rx_data)
        8'h12: lshift <= !emit_brk;
        8'h59: rshift <= !emit_brk;
        8'h58: begin
          // Typematic repeats arrive with caps_held already set and must not re-toggle.
          if (!emit_brk && !caps_held) caps_lock <= !caps_lock;
          caps_held <= !emit_brk;
        end
        default: ;
      endcase
    end
  end

  assign shift_held = lshift | rshift;

  // ---------------------------------------------------------------------------
  // Event FIFO
  // ---------------------------------------------------------------------------
  event_t        mem [FIFO_DEPTH];
  event_t        push_ev, head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, do_push, do_pop;

  always_comb begin
    push_ev.code  = rx_data;
    push_ev.ext   = emit_ext;
    push_ev.brk   = emit_brk;
    push_ev.ascii = (!emit_ext && !emit_brk) ? translate(rx_data, shift_held, caps_lock)
                                             : 8'h00;
  end

  assign full    = (count == DEPTH_CNT);
  assign do_pop  = ev.ev_valid && ev.ev_ready;
  assign do_push = emit && (!full || do_pop);

  // NOTE: storage is not reset; count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_ev;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (emit && full && !do_pop) overflow <= 1'b1;
    end
  end

  // Head fields are masked while empty so stale storage never shows on the bus.
  assign head         = mem[rd_ptr];
  assign ev.ev_valid  = (count != '0);
  assign ev.ev_code   = ev.ev_valid ? head.code  : 8'h00;
  assign ev.ev_ext    = ev.ev_valid ? head.ext   : 1'b0;
  assign ev.ev_break  = ev.ev_valid ? head.brk   : 1'b0;
  assign ev.ev_ascii  = ev.ev_valid ? head.ascii : 8'h00;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench for ps2_scancode_decoder: directed byte sequences push expected
// events into a queue; a negedge monitor pops and compares on every handshake.
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       shift_held, caps_lock, overflow;

  ps2_scancode_decoder_if ev_bus ();

  ps2_scancode_decoder #(.FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .ev        (ev_bus.master),
    .shift_held(shift_held),
    .caps_lock (caps_lock),
    .overflow  (overflow)
  );

  always #10 clk = ~clk;

  // {code, ext, break, ascii}
  logic [17:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [17:0] mk(input logic [7:0] code, input logic ext,
                                     input logic brk, input logic [7:0] ascii);
    return {code, ext, brk, ascii};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    check(name, exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1 check({name, "_idle"}, ev_bus.ev_valid, 1'b0);
  endtask

  // Monitor: one handshake per cycle, sampled away from the active edge.
  initial begin
    logic [17:0] got;
    forever begin
      @(negedge clk);
      if (ev_bus.ev_valid && ev_bus.ev_ready) begin
        got = {ev_bus.ev_code, ev_bus.ev_ext, ev_bus.ev_break, ev_bus.ev_ascii};
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got %h expected none", got);
        end else begin
          check("event", got, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ev_bus.ev_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ev_valid", ev_bus.ev_valid, 1'b0);
    check("rst_ev_code", ev_bus.ev_code, 8'h00);
    check("rst_mods", {shift_held, caps_lock, overflow}, 3'b000);
    @(negedge clk) rst = 1'b0;

    // Plain make/break and one-cycle latency
    exp_q.push_back(mk(8'h1C, 0, 0, 8'h61));
    send_byte(8'h1C);
    check("latency_valid", ev_bus.ev_valid, 1'b1);
    exp_q.push_back(mk(8'h1C, 0, 1, 8'h00));
    send_byte(8'hF0);
    send_byte(8'h1C);
    wait_drain("basic");

    // Shift
    exp_q.push_back(mk(8'h12, 0, 0, 8'h00));
    exp_q.push_back(mk(8'h1C, 0, 0, 8'h41));
    exp_q.push_back(mk(8'h12, 0, 1, 8'h00));
    exp_q.push_back(mk(8'h16, 0, 0, 8'h31));
    send_byte(8'h12);
    check("shift_set", shift_held, 1'b1);
    send_byte(8'h1C);
    send_byte(8'hF0);
    send_byte(8'h12);
    check("shift_clr", shift_held, 1'b0);
    send_byte(8'h16);
    wait_drain("shift");

    // Caps lock with typematic repeat
    exp_q.push_back(mk(8'h58, 0, 0, 8'h00));
    exp_q.push_back(mk(8'h58, 0, 0, 8'h00));
    exp_q.push_back(mk(8'h58, 0, 1, 8'h00));
    exp_q.push_back(mk(8'h1C, 0, 0, 8'h41));
    exp_q.push_back(mk(8'h58, 0, 0, 8'h00));
    send_byte(8'h58);
    check("caps_on", caps_lock, 1'b1);
    send_byte(8'h58);
    check("caps_repeat", caps_lock, 1'b1);
    send_byte(8'hF0);
    send_byte(8'h58);
    send_byte(8'h1C);
    send_byte(8'h58);
    check("caps_off", caps_lock, 1'b0);
    wait_drain("caps");

    // Extended keys and fake shift
    exp_q.push_back(mk(8'h75, 1, 0, 8'h00));
    exp_q.push_back(mk(8'h75, 1, 1, 8'h00));
    send_byte(8'hE0);
    send_byte(8'h75);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    send_byte(8'hE0);
    send_byte(8'h12);
    check("fake_shift", shift_held, 1'b0);
    wait_drain("ext");

    // Pause sequence swallowed, then space
    exp_q.push_back(mk(8'h29, 0, 0, 8'h20));
    foreach (exp_q[i]) ;
    begin
      logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      for (int i = 0; i < 8; i++) send_byte(pause_seq[i]);
    end
    send_byte(8'h29);
    wait_drain("pause");

    // Overflow: six makes into a depth-4 FIFO with the consumer stalled
    ev_bus.ev_ready = 1'b0;
    exp_q.push_back(mk(8'h1C, 0, 0, 8'h61));
    exp_q.push_back(mk(8'h32, 0, 0, 8'h62));
    exp_q.push_back(mk(8'h21, 0, 0, 8'h63));
    exp_q.push_back(mk(8'h23, 0, 0, 8'h64));
    begin
      logic [7:0] ovf_seq [6] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
      for (int i = 0; i < 6; i++) begin
        send_byte(ovf_seq[i]);
        check("ovf_progress", overflow, (i >= 4) ? 1'b1 : 1'b0);
      end
    end
    check("ovf_valid", ev_bus.ev_valid, 1'b1);
    ev_bus.ev_ready = 1'b1;
    wait_drain("ovf_drain");
    check("ovf_sticky", overflow, 1'b1);

    // Reset mid-sequence with a queued event and a pending break prefix
    ev_bus.ev_ready = 1'b0;
    send_byte(8'h1C);
    send_byte(8'hF0);
    rst = 1'b1;
    #5;
    check("mid_rst_valid", ev_bus.ev_valid, 1'b0);
    check("mid_rst_code", ev_bus.ev_code, 8'h00);
    check("mid_rst_ovf", overflow, 1'b0);
    @(negedge clk) rst = 1'b0;
    ev_bus.ev_ready = 1'b1;
    exp_q.push_back(mk(8'h1C, 0, 0, 8'h61));
    send_byte(8'h1C);
    wait_drain("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
